// File: rtl/oddeven_monitor.sv
// Receive-side checker for the 3-bit odd/even counter: predicts each next count
// from the sampled count and K, flags mismatches, and tracks lock, mode and errors.
module oddeven_monitor #(
  parameter int unsigned LOCK_LEN = 4,
  parameter int unsigned ERRW     = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN2,
  input  logic            IN1,
  input  logic            IN0,
  input  logic            K,
  input  logic            CLR,
  output logic            ERR,
  output logic            STICKY,
  output logic            LOCK,
  output logic            MODE,
  output logic [ERRW-1:0] ERRCNT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_LOCKED
  } state_e;

  localparam logic [4:0] LOCK_TARGET = 5'(LOCK_LEN);

  // Same next-state equations as the counter itself.
  function automatic logic [2:0] next_count(input logic [2:0] c, input logic k);
    logic n0, n1, n2;
    n0 = k | (c[2] & c[1] & ~c[0]);
    n1 = (~k & ~c[1]) | (~c[1] & c[0]) | (k & c[1] & ~c[0]);
    n2 = (c[2] & ~c[1]) | (~k & ~c[2] & c[1]) | (k & c[2] & ~c[0]) | (~c[2] & c[1] & c[0]);
    return {n2, n1, n0};
  endfunction

  state_e          state_q, state_d;
  logic [2:0]      prev_q, prev_d;
  logic            prevk_q, prevk_d;
  logic [3:0]      good_q, good_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic            lock_q, lock_d;
  logic            mode_q, mode_d;
  logic [ERRW-1:0] errcnt_q, errcnt_d;

  logic [2:0]      cur;
  logic            match;
  logic [4:0]      good_inc;
  logic [ERRW-1:0] errcnt_base;
  logic            sticky_base;

  assign cur      = {IN2, IN1, IN0};
  assign match    = (cur == next_count(prev_q, prevk_q));
  assign good_inc = {1'b0, good_q} + 5'd1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    good_d  = good_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    prev_d  = cur;
    prevk_d = K;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_TRACK;
        good_d  = '0;
      end
      ST_TRACK: begin
        if (match) begin
          good_d = good_inc[3:0];
          mode_d = prevk_q;
          if (good_inc == LOCK_TARGET) state_d = ST_LOCKED;
        end else begin
          err_d  = 1'b1;
          good_d = '0;
        end
      end
      ST_LOCKED: begin
        if (match) begin
          mode_d = prevk_q;
        end else begin
          err_d   = 1'b1;
          good_d  = '0;
          state_d = ST_TRACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase

    lock_d = (state_d == ST_LOCKED);

    // Clear applies first, then a same-cycle error counts on top of it.
    errcnt_base = CLR ? '0 : errcnt_q;
    sticky_base = CLR ? 1'b0 : sticky_q;
    sticky_d    = sticky_base | err_d;
    if (err_d && !(&errcnt_base)) errcnt_d = errcnt_base + ERRW'(1);
    else                          errcnt_d = errcnt_base;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      prev_q   <= '0;
      prevk_q  <= 1'b0;
      good_q   <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      lock_q   <= 1'b0;
      mode_q   <= 1'b0;
      errcnt_q <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q  <= state_d;
      prev_q   <= prev_d;
      prevk_q  <= prevk_d;
      good_q   <= good_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      lock_q   <= lock_d;
      mode_q   <= mode_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign ERR    = err_q;
  assign STICKY = sticky_q;
  assign LOCK   = lock_q;
  assign MODE   = mode_q;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_oddeven_monitor.sv
// Bench for oddeven_monitor: two instances (ERRW=8 and ERRW=2) share stimulus;
// a table-driven reference pushes expected outputs that a monitor process pops and compares.
module tb_oddeven_monitor;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic IN2 = 1'b0, IN1 = 1'b0, IN0 = 1'b0, K = 1'b0, CLR = 1'b0;

  logic       a_err, a_sticky, a_lock, a_mode;
  logic [7:0] a_errcnt;
  logic       b_err, b_sticky, b_lock, b_mode;
  logic [1:0] b_errcnt;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  oddeven_monitor #(.LOCK_LEN(4), .ERRW(8)) dut_a (
    .CLK(CLK), .RST(RST), .IN2(IN2), .IN1(IN1), .IN0(IN0), .K(K), .CLR(CLR),
    .ERR(a_err), .STICKY(a_sticky), .LOCK(a_lock), .MODE(a_mode), .ERRCNT(a_errcnt)
  );

  oddeven_monitor #(.LOCK_LEN(4), .ERRW(2)) dut_b (
    .CLK(CLK), .RST(RST), .IN2(IN2), .IN1(IN1), .IN0(IN0), .K(K), .CLR(CLR),
    .ERR(b_err), .STICKY(b_sticky), .LOCK(b_lock), .MODE(b_mode), .ERRCNT(b_errcnt)
  );

  // Counter transition tables copied from the listed transitions.
  int nxt1[8] = '{1, 3, 3, 5, 5, 7, 7, 1};
  int nxt0[8] = '{2, 2, 4, 4, 6, 6, 1, 0};

  typedef struct {
    logic err;
    logic sticky;
    logic lock;
    logic mode;
    int   ecnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  // Reference state, index 0 = ERRW 8, index 1 = ERRW 2. st: 0 idle, 1 track, 2 locked.
  int m_st[2], m_prev[2], m_prevk[2], m_good[2], m_ecnt[2];
  bit m_sticky[2], m_mode[2];
  int m_max[2] = '{255, 3};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = 0; m_prev[i] = 0; m_prevk[i] = 0; m_good[i] = 0;
      m_ecnt[i] = 0; m_sticky[i] = 0; m_mode[i] = 0;
    end
  endtask

  task automatic model_step(input int in, input bit k, input bit clr);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      int   pred;
      bit   err;
      err  = 0;
      pred = m_prevk[i] ? nxt1[m_prev[i]] : nxt0[m_prev[i]];
      if (m_st[i] == 0) begin
        m_st[i] = 1; m_good[i] = 0;
      end else if (in == pred) begin
        m_mode[i] = m_prevk[i][0];
        if (m_st[i] == 1) begin
          m_good[i]++;
          if (m_good[i] == 4) m_st[i] = 2;
        end
      end else begin
        err = 1; m_good[i] = 0; m_st[i] = 1;
      end
      if (clr) begin m_ecnt[i] = 0; m_sticky[i] = 0; end
      if (err) begin
        m_sticky[i] = 1;
        if (m_ecnt[i] < m_max[i]) m_ecnt[i]++;
      end
      m_prev[i]  = in;
      m_prevk[i] = int'(k);
      e.err = err; e.sticky = m_sticky[i]; e.lock = (m_st[i] == 2);
      e.mode = m_mode[i]; e.ecnt = m_ecnt[i];
      if (i == 0) q_a.push_back(e); else q_b.push_back(e);
    end
  endtask

  // Inputs change on the falling edge; the task returns 2 time units after the rising edge.
  task automatic drive(input int in, input bit k, input bit clr);
    @(negedge CLK);
    {IN2, IN1, IN0} = in[2:0];
    K   = k;
    CLR = clr;
    model_step(in, k, clr);
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; CLR = 1'b0; K = 1'b0; {IN2, IN1, IN0} = 3'd0;
    model_reset();
    @(posedge CLK);
    #2;
    RST = 1'b1;
  endtask

  // Scoreboard monitor: compares every pushed expectation one unit after its edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        checks += 5;
        if (a_err !== e.err) begin failures++; $display("FAIL sb_a_err t=%0t got=%b want=%b", $time, a_err, e.err); end
        if (a_sticky !== e.sticky) begin failures++; $display("FAIL sb_a_sticky t=%0t got=%b want=%b", $time, a_sticky, e.sticky); end
        if (a_lock !== e.lock) begin failures++; $display("FAIL sb_a_lock t=%0t got=%b want=%b", $time, a_lock, e.lock); end
        if (a_mode !== e.mode) begin failures++; $display("FAIL sb_a_mode t=%0t got=%b want=%b", $time, a_mode, e.mode); end
        if (a_errcnt !== 8'(e.ecnt)) begin failures++; $display("FAIL sb_a_errcnt t=%0t got=%0d want=%0d", $time, a_errcnt, e.ecnt); end
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        checks += 5;
        if (b_err !== e.err) begin failures++; $display("FAIL sb_b_err t=%0t got=%b want=%b", $time, b_err, e.err); end
        if (b_sticky !== e.sticky) begin failures++; $display("FAIL sb_b_sticky t=%0t got=%b want=%b", $time, b_sticky, e.sticky); end
        if (b_lock !== e.lock) begin failures++; $display("FAIL sb_b_lock t=%0t got=%b want=%b", $time, b_lock, e.lock); end
        if (b_mode !== e.mode) begin failures++; $display("FAIL sb_b_mode t=%0t got=%b want=%b", $time, b_mode, e.mode); end
        if (b_errcnt !== 2'(e.ecnt)) begin failures++; $display("FAIL sb_b_errcnt t=%0t got=%0d want=%0d", $time, b_errcnt, e.ecnt); end
      end
    end
  end

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    checks++;
    if ({a_err, a_sticky, a_lock, a_mode} !== 4'b0000 || a_errcnt !== 8'd0) begin
      failures++; $display("FAIL reset_a got=%b%b%b%b cnt=%0d want=0000 cnt=0", a_err, a_sticky, a_lock, a_mode, a_errcnt);
    end
    checks++;
    if ({b_err, b_sticky, b_lock, b_mode} !== 4'b0000 || b_errcnt !== 2'd0) begin
      failures++; $display("FAIL reset_b got=%b%b%b%b cnt=%0d want=0000 cnt=0", b_err, b_sticky, b_lock, b_mode, b_errcnt);
    end
    RST = 1'b1;
  endtask

  task automatic test_k1();
    int seq[6] = '{0, 1, 3, 5, 7, 1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b1, 1'b0);
      if (i == 3) begin
        checks++;
        if (a_lock !== 1'b0) begin failures++; $display("FAIL k1_lock_early got=%b want=0", a_lock); end
      end
      if (i == 4) begin
        checks++;
        if (a_lock !== 1'b1) begin failures++; $display("FAIL k1_lock_4th got=%b want=1", a_lock); end
      end
    end
    checks++;
    if (a_mode !== 1'b1 || a_errcnt !== 8'd0 || a_sticky !== 1'b0) begin
      failures++; $display("FAIL k1_final mode=%b cnt=%0d sticky=%b want mode=1 cnt=0 sticky=0", a_mode, a_errcnt, a_sticky);
    end
  endtask

  task automatic test_k0();
    int seq[6] = '{0, 2, 4, 6, 1, 2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(seq[i], 1'b0, 1'b0);
      if (i == 4) begin
        checks++;
        if (a_lock !== 1'b1) begin failures++; $display("FAIL k0_lock_4th got=%b want=1", a_lock); end
      end
    end
    checks++;
    if (a_mode !== 1'b0 || a_errcnt !== 8'd0 || a_lock !== 1'b1) begin
      failures++; $display("FAIL k0_final mode=%b cnt=%0d lock=%b want mode=0 cnt=0 lock=1", a_mode, a_errcnt, a_lock);
    end
  endtask

  task automatic test_force_error();
    int seq[7]  = '{0, 1, 3, 5, 7, 1, 3};
    int tail[4] = '{5, 7, 1, 3};
    do_reset();
    for (int i = 0; i < 7; i++) drive(seq[i], 1'b1, 1'b0);
    drive(4, 1'b1, 1'b0);
    checks++;
    if (a_err !== 1'b1 || a_errcnt !== 8'd1 || a_sticky !== 1'b1 || a_lock !== 1'b0) begin
      failures++; $display("FAIL force_err err=%b cnt=%0d sticky=%b lock=%b want 1 1 1 0", a_err, a_errcnt, a_sticky, a_lock);
    end
    for (int i = 0; i < 4; i++) begin
      drive(tail[i], 1'b1, 1'b0);
      checks++;
      if (a_err !== 1'b0) begin failures++; $display("FAIL force_err_pulse step=%0d got=%b want=0", i, a_err); end
      checks++;
      if (a_lock !== (i == 3)) begin failures++; $display("FAIL relock step=%0d got=%b want=%b", i, a_lock, (i == 3)); end
    end
  endtask

  task automatic test_k_toggle();
    int cnt;
    bit k, kprev;
    cnt = 0; k = 1'b1; kprev = 1'b0;
    do_reset();
    for (int c = 0; c < 18; c++) begin
      if (c > 0 && c % 3 == 0) k = ~k;
      drive(cnt, k, 1'b0);
      if (c >= 1) begin
        checks++;
        if (a_err !== 1'b0 || a_mode !== kprev) begin
          failures++; $display("FAIL toggle c=%0d err=%b mode=%b want err=0 mode=%b", c, a_err, a_mode, kprev);
        end
      end
      cnt   = k ? nxt1[cnt] : nxt0[cnt];
      kprev = k;
    end
  endtask

  task automatic test_errw2_saturate();
    do_reset();
    drive(0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b1, 1'b0);
      checks++;
      if (b_errcnt !== 2'((i + 1 > 3) ? 3 : i + 1)) begin
        failures++; $display("FAIL sat_b err%0d got=%0d want=%0d", i + 1, b_errcnt, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    drive(0, 1'b1, 1'b1);
    checks++;
    if (b_errcnt !== 2'd1 || b_sticky !== 1'b1 || a_errcnt !== 8'd1) begin
      failures++; $display("FAIL clr_with_err b_cnt=%0d b_sticky=%b a_cnt=%0d want 1 1 1", b_errcnt, b_sticky, a_errcnt);
    end
    drive(1, 1'b1, 1'b1);
    checks++;
    if (b_errcnt !== 2'd0 || b_sticky !== 1'b0 || a_errcnt !== 8'd0 || a_sticky !== 1'b0) begin
      failures++; $display("FAIL clr_alone b_cnt=%0d b_sticky=%b a_cnt=%0d a_sticky=%b want all 0", b_errcnt, b_sticky, a_errcnt, a_sticky);
    end
  endtask

  task automatic test_reset_midop();
    int seq[7] = '{0, 0, 0, 1, 3, 5, 7};
    do_reset();
    for (int i = 0; i < 7; i++) drive(seq[i], 1'b1, 1'b0);
    checks++;
    if (a_lock !== 1'b1 || a_errcnt !== 8'd2) begin
      failures++; $display("FAIL midop_pre lock=%b cnt=%0d want lock=1 cnt=2", a_lock, a_errcnt);
    end
    #1;
    RST = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({a_err, a_sticky, a_lock, a_mode} !== 4'b0000 || a_errcnt !== 8'd0 || b_errcnt !== 2'd0 || b_sticky !== 1'b0) begin
      failures++; $display("FAIL async_reset flags=%b%b%b%b a_cnt=%0d b_cnt=%0d want all 0", a_err, a_sticky, a_lock, a_mode, a_errcnt, b_errcnt);
    end
    @(posedge CLK);
    #2;
    RST = 1'b1;
    drive(3, 1'b1, 1'b0);
    checks++;
    if (a_err !== 1'b0) begin failures++; $display("FAIL post_reset_first got=%b want=0", a_err); end
    drive(3, 1'b1, 1'b0);
    checks++;
    if (a_err !== 1'b1 || a_errcnt !== 8'd1) begin
      failures++; $display("FAIL post_reset_second err=%b cnt=%0d want err=1 cnt=1", a_err, a_errcnt);
    end
  endtask

  initial begin
    test_reset();
    test_k1();
    test_k0();
    test_force_error();
    test_k_toggle();
    test_errw2_saturate();
    test_reset_midop();
    @(posedge CLK);
    #3;
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain left_a=%0d left_b=%0d want 0", q_a.size(), q_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/oddeven_monitor.md
# oddeven_monitor

Receive-side checker for the 3-bit odd/even counter. It samples the counter outputs and the K mode input on every clock edge, predicts each next count from the counter's next-state equations, and flags any mismatch. It also reports lock status, the current counting mode and a saturating error count. It sits beside the counter in the test and diagnostic path, on the same clock, and has no effect on the counter.

## Interface
- LOCK_LEN, 4: number of consecutive correct transitions required to assert LOCK (range 1..15).
- ERRW, 8: width of the error counter.
- CLK  input  1  rising-edge clock, shared with the counter.
- RST  input  1  asynchronous, active-low reset.
- IN2, IN1, IN0  input  1 each  observed counter outputs; IN2 is the MSB.
- K  input  1  mode input, the same net that drives the counter.
- CLR  input  1  synchronous clear of ERRCNT and STICKY.
- ERR  output  1  one-cycle pulse on a mismatched transition.
- STICKY  output  1  set by any ERR; held until CLR or reset.
- LOCK  output  1  high while in LOCKED.
- MODE  output  1  K value of the last matched transition (1 = odd sequence).
- ERRCNT  output  ERRW  saturating count of mismatches.

## Operation
- Reference next-state function f(c, k), with c = {c2, c1, c0}:
  - n0 = k | (c2 & c1 & ~c0)
  - n1 = (~k & ~c1) | (~c1 & c0) | (k & c1 & ~c0)
  - n2 = (c2 & ~c1) | (~k & ~c2 & c1) | (k & c2 & ~c0) | (~c2 & c1 & c0)
- Resulting transitions for k=1: 0→1, 1→3, 2→3, 3→5, 4→5, 5→7, 6→7, 7→1.
- Resulting transitions for k=0: 0→2, 1→2, 2→4, 3→4, 4→6, 5→6, 6→1, 7→0.
- Registers: PREV[2:0], PREVK, GOOD (4-bit run counter), the state register, and the outputs.
- At every edge, PREV is loaded from {IN2, IN1, IN0} and PREVK from K.
- State machine:
  - IDLE: no valid PREV yet. On the next edge go to TRACK with no compare and GOOD=0.
  - TRACK: compare the current input with f(PREV, PREVK).
    - On a match: GOOD+1 and MODE=PREVK. When GOOD+1 equals LOCK_LEN, go to LOCKED.
    - On a mismatch: ERR=1 and GOOD=0.
  - LOCKED: compare the same way.
    - On a match: stay, MODE=PREVK, GOOD holds.
    - On a mismatch: ERR=1, GOOD=0, go to TRACK, LOCK falls.
- ERRCNT increments by 1 on each ERR and saturates at 2^ERRW−1; it never wraps.
- CLR in the same cycle as ERR: ERRCNT=1 and STICKY=1, because the clear is applied first and then the new error.
- CLR alone: ERRCNT=0 and STICKY=0. Lock state and GOOD are unaffected.
- K toggling mid-stream is legal and is not an error; the prediction always uses PREVK.

## Timing
- Sampling: at edge t the monitor captures the pre-update count and K at the same instant the counter does.
- Compare: at edge t+1 the input is checked against f(PREV, PREVK).
- ERR, ERRCNT, STICKY and MODE update on the edge where the compare is made and are registered, so they are visible one cycle after the offending value is presented.
- LOCK rises on the edge of the LOCK_LEN-th consecutive match.
- The first compare happens on the second edge after reset release. No ERR is possible on the first edge.
- Reset asserted at any time, including mid-operation, asynchronously forces:
  - state=IDLE
  - PREV=0, PREVK=0, GOOD=0
  - ERR=0, STICKY=0, LOCK=0, MODE=0, ERRCNT=0
- The first edge after reset release is treated as IDLE.

## Test plan
- Counter driven with K=1 after reset:
  - Observe 0,1,3,5,7,1.
  - LOCK=1 on the 4th matched transition.
  - MODE=1, ERR never asserted, ERRCNT=0.
- Counter driven with K=0:
  - Observe 0,2,4,6,1,2.
  - LOCK after 4 matches.
  - MODE=0, ERRCNT=0.
- While LOCKED (K=1), force IN for one cycle to 4 where 5 is expected:
  - ERR pulses for exactly 1 cycle, then ERRCNT=1, STICKY=1, LOCK=0.
  - The following transition (4→5 under K=1) is a match.
  - Relock after 4 matches.
- Toggle K every 3 clocks with the counter connected:
  - No ERR at any time.
  - MODE follows the registered K with a 1-cycle lag.
- ERRW=2 with 5 forced mismatches:
  - ERRCNT saturates at 3.
  - CLR concurrent with the 5th error gives ERRCNT=1.
  - CLR alone then gives ERRCNT=0 and STICKY=0.
- Assert RST for one cycle while LOCKED with ERRCNT=2:
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - No compare on the first edge after release; the second edge compares normally.
